// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store bridge: RV32I func3 codes,
// FSM states, byte-enable bases and the func3 -> access size decode.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Undefined codes (011, 11x) fall through to a word access.
  function automatic lsu_size_e lsu_size(input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_BU: return SZ_BYTE;
      LSU_H, LSU_HU: return SZ_HALF;
      LSU_W:         return SZ_WORD;
      default:       return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and misalign
// detection for the request side; lane select and sign/zero extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  input  logic [2:0]  rsp_func3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rdata_raw,
  output logic [31:0] rdata_ext
);

  lsu_size_e  req_size;
  lsu_size_e  rsp_size;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        sext;

  always_comb begin
    req_size   = lsu_size(func3);
    be         = '0;
    wdata_rep  = '0;
    misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: begin
        be        = BE_BYTE << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = BE_HALF << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        be         = BE_WORD;
        wdata_rep  = wdata;
        misaligned = |addr_lo;
      end
    endcase
  end

  always_comb begin
    rsp_size = lsu_size(rsp_func3);
    sext     = ~rsp_func3[2];
    case (rsp_addr_lo)
      2'd0:    lane_byte = rdata_raw[7:0];
      2'd1:    lane_byte = rdata_raw[15:8];
      2'd2:    lane_byte = rdata_raw[23:16];
      default: lane_byte = rdata_raw[31:24];
    endcase
    lane_half = rsp_addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    case (rsp_size)
      SZ_BYTE: rdata_ext = {{24{sext & lane_byte[7]}}, lane_byte};
      SZ_HALF: rdata_ext = {{16{sext & lane_half[15]}}, lane_half};
      default: rdata_ext = rdata_raw;
    endcase
  end

endmodule

// File: rtl/lsu_bridge.sv
// Memory-stage load/store unit: issues one req/gnt/rvalid bus transaction per
// aligned request, stalling the pipeline until the response (or timeout).
module lsu_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          mem_rd_i,
  input  logic          mem_wr_i,
  input  logic [2:0]    func3_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          stall_o,
  output logic          misalign_o,
  output logic          timeout_o,
  output logic          bus_req_o,
  input  logic          bus_gnt_i,
  output logic          bus_we_o,
  output logic [3:0]    bus_be_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic          bus_rvalid_i,
  input  logic [DW-1:0] bus_rdata_i
);

  localparam int unsigned    CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  lsu_state_e    state;
  logic [CW-1:0] tmo_cnt;
  logic [2:0]    lat_func3;
  logic [1:0]    lat_addr_lo;

  logic          req_valid;
  logic          req_issue;
  logic          misaligned;
  logic [3:0]    be_next;
  logic [DW-1:0] wdata_next;
  logic [DW-1:0] rdata_ext;
  logic          tmo_hit;

  lsu_align u_align (
    .func3       (func3_i),
    .addr_lo     (addr_i[1:0]),
    .wdata       (wdata_i),
    .be          (be_next),
    .wdata_rep   (wdata_next),
    .misaligned  (misaligned),
    .rsp_func3   (lat_func3),
    .rsp_addr_lo (lat_addr_lo),
    .rdata_raw   (bus_rdata_i),
    .rdata_ext   (rdata_ext)
  );

  assign req_valid = mem_rd_i | mem_wr_i;
  assign req_issue = (state == ST_IDLE) && req_valid && !misaligned;

  // Input-driven flags are gated by reset so every output reads 0 while it is held.
  assign stall_o    = !rst_i && (req_issue || state == ST_REQ || state == ST_RSP);
  assign misalign_o = !rst_i && (state == ST_IDLE) && req_valid && misaligned;

  // Fires in the last waiting cycle; a gnt/rvalid in that same cycle still wins.
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign timeout_o = tmo_hit && ((state == ST_REQ && !bus_gnt_i) ||
                                 (state == ST_RSP && !bus_rvalid_i));

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      lat_func3   <= '0;
      lat_addr_lo <= '0;
      rdata_o     <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (req_issue) begin
            lat_func3   <= func3_i;
            lat_addr_lo <= addr_i[1:0];
            bus_we_o    <= mem_wr_i;
            bus_be_o    <= be_next;
            bus_addr_o  <= {addr_i[AW-1:2], 2'b00};
            bus_wdata_o <= wdata_next;
            bus_req_o   <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            tmo_cnt   <= '0;
            state     <= ST_RSP;
          end else if (timeout_o) begin
            bus_req_o <= 1'b0;
            tmo_cnt   <= '0;
            if (!bus_we_o) rdata_o <= '0;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RSP: begin
          if (bus_rvalid_i) begin
            if (!bus_we_o) rdata_o <= rdata_ext;
            tmo_cnt <= '0;
            state   <= ST_DONE;
          end else if (timeout_o) begin
            if (!bus_we_o) rdata_o <= '0;
            tmo_cnt <= '0;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
